// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
// The controller side uses the slave modport; the pipeline side uses master.
// Optional macro HAZARD_PERF_CNT_EN adds the stall/flush performance counters.
interface hazard_ctrl_if;
  // ID stage request
  logic       ID_insn_vld;
  logic [4:0] ID_rs1_addr;
  logic [4:0] ID_rs2_addr;
  logic       ID_rs1_used;
  logic       ID_rs2_used;
  logic [4:0] ID_rd_addr;
  logic       ID_rd_wren;
  // EX redirect
  logic       EX_br_taken;
  // WB retire
  logic [4:0] WB_rd_addr;
  logic       WB_rd_wren;
  logic       WB_insn_vld;
  // Sequencing controls back to the pipeline
  logic       o_stall_if;
  logic       o_stall_id;
  logic       o_flush_id;
  logic       o_flush_ex;
  logic       o_sb_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;

  modport slave (
    input  ID_insn_vld, ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
           ID_rd_addr, ID_rd_wren, EX_br_taken, WB_rd_addr, WB_rd_wren, WB_insn_vld,
    output o_stall_if, o_stall_id, o_flush_id, o_flush_ex, o_sb_err,
           o_stall_cnt, o_flush_cnt
  );

  modport master (
    output ID_insn_vld, ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
           ID_rd_addr, ID_rd_wren, EX_br_taken, WB_rd_addr, WB_rd_wren, WB_insn_vld,
    input  o_stall_if, o_stall_id, o_flush_id, o_flush_ex, o_sb_err,
           o_stall_cnt, o_flush_cnt
  );
`else
  modport slave (
    input  ID_insn_vld, ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
           ID_rd_addr, ID_rd_wren, EX_br_taken, WB_rd_addr, WB_rd_wren, WB_insn_vld,
    output o_stall_if, o_stall_id, o_flush_id, o_flush_ex, o_sb_err
  );

  modport master (
    output ID_insn_vld, ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
           ID_rd_addr, ID_rd_wren, EX_br_taken, WB_rd_addr, WB_rd_wren, WB_insn_vld,
    input  o_stall_if, o_stall_id, o_flush_id, o_flush_ex, o_sb_err
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the non-forwarding 5-stage core.
// Tracks in-flight register writes (ID issue -> WB retire) in a per-register
// counter scoreboard, stalls IF/ID on RAW hazards, and flushes IF/ID and ID/EX
// on a taken branch resolved in EX. All controls are combinational from the
// registered counters and the current inputs.
// Optional macro HAZARD_PERF_CNT_EN adds free-running stall/flush counters.
module hazard_ctrl #(
  parameter int NREG      = 32,
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic    i_clk,
  input  logic    i_rst,
  hazard_ctrl_if.slave hz
);

  localparam int              AW      = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             sb_err_q, sb_err_d;

  logic             retire, issue, haz;
  logic             busy_rs1, busy_rs2;
  logic [CNT_W-1:0] rs1_cnt, rs2_cnt;

  assign retire = hz.WB_insn_vld & hz.WB_rd_wren & (hz.WB_rd_addr != '0);

  // Source readiness; a write-through regfile makes the last retiring write visible to ID.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rs1_cnt  = cnt_q[hz.ID_rs1_addr];
    rs2_cnt  = cnt_q[hz.ID_rs2_addr];
    busy_rs1 = (rs1_cnt != '0);
    busy_rs2 = (rs2_cnt != '0);
    if (WB_BYPASS && retire && (hz.WB_rd_addr == hz.ID_rs1_addr) && (rs1_cnt == CNT_ONE))
      busy_rs1 = 1'b0;
    if (WB_BYPASS && retire && (hz.WB_rd_addr == hz.ID_rs2_addr) && (rs2_cnt == CNT_ONE))
      busy_rs2 = 1'b0;
  end

  assign haz = hz.ID_insn_vld &
               ((hz.ID_rs1_used & (hz.ID_rs1_addr != '0) & busy_rs1) |
                (hz.ID_rs2_used & (hz.ID_rs2_addr != '0) & busy_rs2));

  assign issue = hz.ID_insn_vld & hz.ID_rd_wren & (hz.ID_rd_addr != '0) &
                 ~haz & ~hz.EX_br_taken;

  // Stall/flush decode: a taken branch overrides a hazard in the same cycle.
  always_comb begin
    hz.o_stall_if = 1'b0;
    hz.o_stall_id = 1'b0;
    hz.o_flush_id = 1'b0;
    hz.o_flush_ex = 1'b0;
    if (hz.EX_br_taken) begin
      hz.o_flush_id = 1'b1;
      hz.o_flush_ex = 1'b1;
    end else if (haz) begin
      hz.o_stall_if = 1'b1;
      hz.o_stall_id = 1'b1;
      hz.o_flush_ex = 1'b1;
    end
  end

  // Scoreboard next state: saturate at both ends and flag the error instead of wrapping.
  always_comb begin
    logic inc, dec;
    inc      = 1'b0;
    dec      = 1'b0;
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      inc      = issue  && (hz.ID_rd_addr == AW'(r));
      dec      = retire && (hz.WB_rd_addr == AW'(r));
      if (inc && !dec) begin
        if (cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the counter array is flop storage read from the first cycle, so it must be reset.
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      sb_err_q <= sb_err_d;
    end
  end

  assign hz.o_sb_err = sb_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Performance counters; both wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (haz && !hz.EX_br_taken) stall_cnt_d = stall_cnt_q + 32'd1;
    if (hz.EX_br_taken)         flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.o_stall_cnt = stall_cnt_q;
  assign hz.o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the non-forwarding 5-stage core.
- Holds a per-register scoreboard of in-flight destination writes between ID issue and WB retire.
- Stalls IF/ID on RAW hazards and inserts a bubble into ID/EX.
- Flushes IF/ID and ID/EX when EX resolves a taken branch or jump.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 2, per-register in-flight counter width; 3 outstanding writes max in a 5-stage pipe.
- WB_BYPASS, 1, 1 means the regfile writes through, so a register retiring this cycle counts as ready for ID.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- ID_insn_vld  in  1  valid instruction in ID.
- ID_rs1_addr  in  5  source 1 address.
- ID_rs2_addr  in  5  source 2 address.
- ID_rs1_used  in  1  instruction reads rs1.
- ID_rs2_used  in  1  instruction reads rs2.
- ID_rd_addr  in  5  destination address.
- ID_rd_wren  in  1  instruction writes rd.
- EX_br_taken  in  1  redirect resolved in EX this cycle.
- WB_rd_addr  in  5  retiring destination.
- WB_rd_wren  in  1  regfile write this cycle.
- WB_insn_vld  in  1  valid instruction in WB.
- o_stall_if  out  1  hold PC.
- o_stall_id  out  1  hold IF/ID register.
- o_flush_id  out  1  clear IF/ID to bubble.
- o_flush_ex  out  1  load bubble (all control 0, insn_vld 0) into ID/EX.
- o_sb_err  out  1  sticky scoreboard underflow or overflow.

Behaviour:
- Reset (async, i_rst=1): all counters 0; o_sb_err 0. Combinational outputs follow, so stalls and flushes are 0 when no EX_br_taken.
- retire = WB_insn_vld & WB_rd_wren & (WB_rd_addr!=0).
- busy(r) = cnt[r]!=0, except when WB_BYPASS=1 & retire & WB_rd_addr==r & cnt[r]==1; then busy(r)=0.
- haz = ID_insn_vld & ((ID_rs1_used & rs1!=0 & busy(rs1)) | (ID_rs2_used & rs2!=0 & busy(rs2))).
- Outputs are combinational from the registered counters plus the current inputs; there is no added latency.
  - EX_br_taken=1: o_flush_id=1, o_flush_ex=1, o_stall_if=0, o_stall_id=0. The branch overrides the hazard.
  - else haz=1: o_stall_if=1, o_stall_id=1, o_flush_ex=1, o_flush_id=0.
  - else all four outputs are 0.
- issue = ID_insn_vld & ID_rd_wren & (ID_rd_addr!=0) & ~haz & ~EX_br_taken. The ID instruction advances to EX.
- Counter update at the clock edge:
  - issue and retire on the same register: the counter is unchanged.
  - otherwise the issue register is incremented and the retire register is decremented, independently.
- Boundary conditions:
  - retire while cnt==0: no decrement; o_sb_err set to 1.
  - issue while cnt==max: no increment; o_sb_err set to 1.
  - o_sb_err clears only on reset.
- x0 is never tracked: reads of x0 never stall, and writes to x0 never count.
- Stalls on the same hazard continue every cycle until the retire drops busy to 0. No timeout.
- Reset asserted mid-stall: counters clear at once, so the stall drops in the same cycle. The pipeline registers are reset by the same i_rst.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs o_stall_cnt[31:0] and o_flush_cnt[31:0], both reset to 0.
  - o_stall_cnt increments every cycle with haz=1 & EX_br_taken=0.
  - o_flush_cnt increments every cycle with EX_br_taken=1.
  - Both wrap at 2^32-1 -> 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then ID issues add x5 (rd_wren=1) → next cycle the x5 counter is 1. A consumer of x5 in ID → o_stall_if=o_stall_id=o_flush_ex=1 until the cycle WB retires x5; with WB_BYPASS=1 the stall drops in that same cycle.
- Back-to-back writes to x7 issue on 3 cycles, with no retires in that window → counter=3. Three retires of x7 → counter returns to 0. A consumer of x7 stalls until the third retire.
- EX_br_taken=1 while ID holds a hazarding consumer → o_flush_id=1, o_flush_ex=1, stalls 0, and no issue increment.
- Issue x3 and retire x3 in the same cycle with counter=1 → counter stays 1; o_sb_err stays 0.
- Retire x9 with counter 0 → o_sb_err=1 and it stays set. ID reading x0 while x0 is written in WB → no stall.
- With HAZARD_PERF_CNT_EN: 4 hazard cycles and 2 branch-taken cycles → o_stall_cnt=4, o_flush_cnt=2. Assert i_rst mid-stall → both counts 0 and the stall is deasserted immediately.
